adc_burst_writer: RTL and testbench

//  Write side of the ADC capture path. Samples the parallel ADC bus every clk_a cycle and

---
 rtl/adc_burst_writer.sv | 170 +++++++++++++++++
 tb/tb_adc_burst_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_burst_writer.sv
// adc_burst_writer: write side of the ADC capture path.
// Registers the ADC bus every clk_a cycle and, once armed and triggered, pushes
// a decimated burst into the async FIFO write port. A full FIFO drops the
// sample and bumps a saturating drop counter instead of stalling.
module adc_burst_writer #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned DECIM_W    = 8,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned OVF_W      = 16
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  stop,
  input  logic [DECIM_W-1:0]    decim,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [OVF_W-1:0]      ovf_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nx;

  logic [DATA_WIDTH-1:0]   adc_q;
  logic                    trig_d;
  logic                    trig_edge;

  logic [DECIM_W-1:0]      decim_r;
  logic [LEN_W-1:0]        len_r;
  logic [DECIM_W-1:0]      dcnt;
  logic [DECIM_W-1:0]      dcnt_nx;
  logic [LEN_W-1:0]        sel_cnt;
  logic [LEN_W-1:0]        sel_cnt_nx;

  logic                    latch_cfg;
  logic                    do_write;
  logic                    do_drop;

  // Rising edge of the trigger level, relative to last cycle's sample.
  assign trig_edge = trig & ~trig_d;

  assign busy = (state == S_ARMED) || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  // Input pipeline: ADC sample and trigger history, always running.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      adc_q  <= '0;
      trig_d <= 1'b0;
    end else begin
      adc_q  <= adc_data;
      trig_d <= trig;
    end
  end

  // Next-state, decimation and selection decode.
  always_comb begin
    state_nx   = state;
    dcnt_nx    = dcnt;
    sel_cnt_nx = sel_cnt;
    latch_cfg  = 1'b0;
    do_write   = 1'b0;
    do_drop    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_nx  = S_ARMED;
          latch_cfg = 1'b1;
        end
      end
      S_ARMED: begin
        // arm is ignored here; only an edge seen while already armed counts.
        if (trig_edge) begin
          state_nx = S_CAPTURE;
          dcnt_nx  = '0;
        end
      end
      S_CAPTURE: begin
        if (stop) begin
          // stop pre-empts any selection in the same cycle.
          state_nx = S_DONE;
        end else if (dcnt == '0) begin
          dcnt_nx    = decim_r;
          sel_cnt_nx = sel_cnt + LEN_W'(1);
          do_write   = ~fifo_full;
          do_drop    = fifo_full;
          if ((len_r != '0) && (sel_cnt_nx == len_r)) begin
            state_nx = S_DONE;
          end
        end else begin
          dcnt_nx = dcnt - DECIM_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Burst configuration, captured on arm.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      decim_r <= '0;
      len_r   <= '0;
    end else if (latch_cfg) begin
      decim_r <= decim;
      len_r   <= burst_len;
    end
  end

  // Decimation and selection counters.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      dcnt    <= '0;
      sel_cnt <= '0;
    end else begin
      dcnt <= dcnt_nx;
      if (latch_cfg) begin
        sel_cnt <= '0;
      end else begin
        sel_cnt <= sel_cnt_nx;
      end
    end
  end

  // Saturating count of samples dropped on a full FIFO.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (latch_cfg) begin
      ovf_cnt <= '0;
    end else if (do_drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  // FIFO write port: one-cycle strobe per written sample, data held otherwise.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_data <= adc_q;
      end
    end
  end

endmodule

// File: tb/tb_adc_burst_writer.sv
// Testbench for adc_burst_writer: randomized trials checked cycle by cycle
// against expectations derived from the recorded input trace.
module tb_adc_burst_writer;

  localparam int unsigned DW      = 14;
  localparam int unsigned DCW     = 8;
  localparam int unsigned LW      = 16;
  localparam int unsigned OW      = 3;
  localparam int          HN      = 16384;
  localparam int          OVF_MAX = (1 << OW) - 1;

  logic           clk_a = 1'b0;
  logic           rst;
  logic [DW-1:0]  adc_data;
  logic           arm;
  logic           trig;
  logic           stop;
  logic [DCW-1:0] decim;
  logic [LW-1:0]  burst_len;
  logic           fifo_full;
  logic           wr_en;
  logic [DW-1:0]  wr_data;
  logic           busy;
  logic           done;
  logic [OW-1:0]  ovf_cnt;

  int total = 0;
  int bad   = 0;

  // Input trace and expectations, indexed by clock edge number.
  bit             arm_h  [HN];
  bit             trig_h [HN];
  bit             stop_h [HN];
  bit             full_h [HN];
  bit             rst_h  [HN];
  logic [DW-1:0]  adc_h  [HN];
  logic [DCW-1:0] dec_h  [HN];
  logic [LW-1:0]  len_h  [HN];
  bit             exp_wr [HN];
  logic [DW-1:0]  exp_dat[HN];
  bit             drop_h [HN];

  int next_cyc = 1;

  always #5 clk_a = ~clk_a;

  adc_burst_writer #(
    .DATA_WIDTH(DW),
    .DECIM_W   (DCW),
    .LEN_W     (LW),
    .OVF_W     (OW)
  ) dut (
    .clk_a    (clk_a),
    .rst      (rst),
    .adc_data (adc_data),
    .arm      (arm),
    .trig     (trig),
    .stop     (stop),
    .decim    (decim),
    .burst_len(burst_len),
    .fifo_full(fifo_full),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .ovf_cnt  (ovf_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply trace entry n, let edge n happen, return 1 time unit later.
  task automatic drive(input int n);
    rst       = rst_h[n];
    arm       = arm_h[n];
    trig      = trig_h[n];
    stop      = stop_h[n];
    fifo_full = full_h[n];
    adc_data  = adc_h[n];
    decim     = dec_h[n];
    burst_len = len_h[n];
    @(posedge clk_a);
    #1;
  endtask

  // One capture: arm at edge a, random trigger/stop/full traffic, then either a
  // forced trigger+stop at the end or a reset rst_off cycles into capture.
  task automatic run_trial(input int unsigned d, input int unsigned len,
                           input int unsigned full_pct, input int unsigned stop_pct,
                           input int unsigned arm_pct, input bit ramp,
                           input bit same_edge, input int rst_off);
    int base, a, last, lim, e, c, f, s, nsel, drops, r, arm_end;
    bit busy_e, done_e, wr_e;
    int ovf_e;
    base = next_cyc;
    a    = base + 3;
    if (rst_off >= 0) begin
      r    = a + 3 + rst_off;
      last = r + 6;
    end else begin
      r    = -1;
      last = a + int'(d + 1) * ((len != 0) ? int'(len) : 12) + 12;
    end
    if (last >= HN) begin
      $display("FAIL trace_space last=%0d limit=%0d", last, HN);
      $fatal(1);
    end

    for (int n = base; n <= last; n++) begin
      rst_h[n]  = 1'b0;
      arm_h[n]  = 1'b0;
      stop_h[n] = ($urandom_range(0, 99) < stop_pct);
      full_h[n] = ($urandom_range(0, 99) < full_pct);
      adc_h[n]  = ramp ? DW'(n) : DW'($urandom);
      dec_h[n]  = DCW'($urandom);
      len_h[n]  = LW'($urandom);
      trig_h[n] = ($urandom_range(0, 3) == 0) ? ~trig_h[n-1] : trig_h[n-1];
      exp_wr[n] = 1'b0;
      drop_h[n] = 1'b0;
    end
    arm_h[a] = 1'b1;
    dec_h[a] = DCW'(d);
    len_h[a] = LW'(len);
    if (same_edge) begin
      trig_h[a-1] = 1'b0;
      trig_h[a]   = 1'b1;
      trig_h[a+1] = 1'b1;
      trig_h[a+2] = 1'b0;
    end
    if (r >= 0) begin
      trig_h[a+1] = 1'b0;
      trig_h[a+2] = 1'b1;
      rst_h[r]    = 1'b1;
    end else begin
      trig_h[last-2] = 1'b0;
      trig_h[last-1] = 1'b1;
      stop_h[last]   = 1'b1;
    end

    // Expected behaviour from the trace: first fresh edge after arm, first
    // stop after capture starts, selections every d+1 cycles from edge+1.
    lim = (r >= 0) ? r - 1 : last;
    e = -1;
    for (int n = a + 1; n <= lim; n++) begin
      if (trig_h[n] && !trig_h[n-1]) begin
        e = n;
        break;
      end
    end
    c = -1;
    if (e >= 0) begin
      for (int n = e + 1; n <= lim; n++) begin
        if (stop_h[n]) begin
          c = n;
          break;
        end
      end
    end
    f    = -1;
    nsel = 0;
    if (e >= 0) begin
      s = e + 1;
      while ((s <= lim) && ((c < 0) || (s < c)) && (f < 0)) begin
        nsel++;
        if (full_h[s]) begin
          drop_h[s] = 1'b1;
        end else begin
          exp_wr[s]  = 1'b1;
          exp_dat[s] = adc_h[s-1];
        end
        if ((len != 0) && (nsel == int'(len))) f = s;
        s += int'(d) + 1;
      end
      if ((f < 0) && (c >= 0)) f = c;
    end

    // Extra arm pulses only while armed or capturing, where they must be ignored.
    arm_end = ((f >= 0) && (f < lim)) ? f : lim;
    for (int n = a + 1; n <= arm_end; n++) begin
      arm_h[n] = ($urandom_range(0, 99) < arm_pct);
    end

    drops = 0;
    for (int n = base; n <= last; n++) begin
      drive(n);
      if (n < a) begin
        check($sformatf("pre_wr_en@%0d", n), wr_en, 0);
        continue;
      end
      if (drop_h[n]) drops++;
      if ((r >= 0) && (n >= r)) begin
        busy_e = 1'b0;
        done_e = 1'b0;
        ovf_e  = 0;
        wr_e   = 1'b0;
      end else begin
        busy_e = (f < 0) || (n < f);
        done_e = (f >= 0) && (n >= f);
        ovf_e  = (drops > OVF_MAX) ? OVF_MAX : drops;
        wr_e   = exp_wr[n];
      end
      check($sformatf("wr_en@%0d", n), wr_en, wr_e);
      check($sformatf("busy@%0d", n), busy, busy_e);
      check($sformatf("done@%0d", n), done, done_e);
      check($sformatf("ovf_cnt@%0d", n), ovf_cnt, ovf_e);
      if (wr_e) check($sformatf("wr_data@%0d", n), wr_data, exp_dat[n]);
    end
    next_cyc = last + 1;
  endtask

  initial begin
    rst       = 1'b1;
    arm       = 1'b0;
    trig      = 1'b0;
    stop      = 1'b0;
    fifo_full = 1'b0;
    adc_data  = '0;
    decim     = '0;
    burst_len = '0;
    trig_h[0] = 1'b0;
    repeat (3) @(posedge clk_a);
    #1;
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ovf_cnt", ovf_cnt, 0);

    //        d    len full stop arm ramp same rst
    run_trial(0,   4,  0,   0,   0,  1,   0,   -1);
    run_trial(2,   3,  0,   0,   0,  1,   0,   -1);
    run_trial(0,   6,  35,  0,   0,  1,   0,   -1);
    run_trial(0,   0,  0,   4,   0,  1,   0,   -1);
    run_trial(1,   0,  20,  5,   10, 0,   0,   -1);
    run_trial(0,   5,  0,   0,   50, 1,   1,   -1);
    run_trial(1,   10, 100, 0,   0,  0,   0,   -1);
    run_trial(255, 2,  0,   0,   5,  0,   0,   -1);
    run_trial(0,   8,  20,  0,   20, 0,   0,   3);
    run_trial(0,   1,  0,   0,   0,  0,   1,   -1);

    for (int t = 0; t < 40; t++) begin
      run_trial($urandom_range(0, 3), $urandom_range(0, 8), $urandom_range(0, 40),
                $urandom_range(0, 6), $urandom_range(0, 30), 1'b0,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
